// File: rtl/pcie_dllp_pkg.sv
// Shared constants, state encoding and DLLP content layout for the DLLP receive checker.
package pcie_dllp_pkg;

  localparam int unsigned DLLP_BYTES     = 6;
  localparam int unsigned DLLP_CRC_BYTES = 2;

  localparam logic [15:0] DLLP_CRC_INIT = 16'hFFFF;
  localparam logic [15:0] DLLP_CRC_POLY = 16'hD008;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } dllp_state_t;

  typedef struct packed {
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] byte2;
    logic [7:0] byte3;
  } dllp_t;

endpackage

// File: rtl/pcie_dllp_crc8.sv
// Combinational one-byte step of the reflected 16-bit DLLP CRC.
module pcie_dllp_crc8 #(
  parameter logic [15:0] CRC_POLY = 16'hD008
) (
  input  logic [15:0] crcIn,
  input  logic [7:0]  data,
  output logic [15:0] crcOut
);

  always_comb begin
    logic [15:0] c;
    c = crcIn ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crcOut = c;
  end

endmodule

// File: rtl/pcie_dllp_rx_check.sv
// Byte-serial DLLP receive framer and CRC checker with a registered valid/ready output.
// Optional good/bad DLLP counters are built when PCIE_DLLP_RX_STATS_EN is defined.
module pcie_dllp_rx_check
  import pcie_dllp_pkg::*;
#(
  parameter logic [15:0] CRC_INIT  = DLLP_CRC_INIT,
  parameter logic [15:0] CRC_POLY  = DLLP_CRC_POLY,
  parameter bit          CHECK_CRC = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_sop_i,
  input  logic [7:0]  in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_dllp_o,
  output logic        crc_err_o,
  output logic        abort_o,
  output logic [15:0] good_cnt_o,
  output logic [15:0] bad_cnt_o
);

  localparam logic [2:0] LAST_IDX  = 3'(DLLP_BYTES - 1);
  localparam logic [2:0] CRC0_IDX  = 3'(DLLP_BYTES - DLLP_CRC_BYTES);

  dllp_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] crc_q, crc_in, crc_out;
  logic [7:0]  crc_lo_q;
  dllp_t       content_q, out_q;
  logic        out_valid_q, crc_err_q, abort_q;
  logic        accept, start, done, frame_bad;

  // ---------------- output / handshake decode ----------------
  always_comb begin
    in_ready_o = !out_valid_q || out_ready_i;
    accept     = in_valid_i && in_ready_o;
    start      = accept && in_sop_i;
    done       = accept && !in_sop_i && (state_q == COLLECT) && (idx_q == LAST_IDX);
    frame_bad  = CHECK_CRC &&
                 !((crc_lo_q == ~crc_q[7:0]) && (in_data_i == ~crc_q[15:8]));
  end

  assign out_valid_o = out_valid_q;
  assign out_dllp_o  = out_q;
  assign crc_err_o   = crc_err_q;
  assign abort_o     = abort_q;

  // ---------------- state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (start) begin
      state_d = COLLECT;
      idx_d   = 3'd1;
    end else if (accept && state_q == COLLECT) begin
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // The sop byte reseeds, so it steps from CRC_INIT instead of the running value.
  assign crc_in = in_sop_i ? CRC_INIT : crc_q;

  pcie_dllp_crc8 #(.CRC_POLY(CRC_POLY)) u_crc (
    .crcIn  (crc_in),
    .data   (in_data_i),
    .crcOut (crc_out)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q     <= CRC_INIT;
      crc_lo_q  <= '0;
      content_q <= '0;
    end else if (start) begin
      crc_q           <= crc_out;
      content_q.byte0 <= in_data_i;
    end else if (accept && state_q == COLLECT) begin
      case (idx_q)
        3'd1: begin crc_q <= crc_out; content_q.byte1 <= in_data_i; end
        3'd2: begin crc_q <= crc_out; content_q.byte2 <= in_data_i; end
        3'd3: begin crc_q <= crc_out; content_q.byte3 <= in_data_i; end
        CRC0_IDX: crc_lo_q <= in_data_i;
        default: ;
      endcase
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      crc_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= start && (state_q == COLLECT);
      if (done) begin
        out_valid_q <= 1'b1;
        out_q       <= content_q;
        crc_err_q   <= frame_bad;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef PCIE_DLLP_RX_STATS_EN
  logic [15:0] good_cnt_q, bad_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else if (out_valid_q && out_ready_i) begin
      if (crc_err_q) begin
        if (bad_cnt_q != '1) bad_cnt_q <= bad_cnt_q + 16'd1;
      end else begin
        if (good_cnt_q != '1) good_cnt_q <= good_cnt_q + 16'd1;
      end
    end
  end

  assign good_cnt_o = good_cnt_q;
  assign bad_cnt_o  = bad_cnt_q;
`else
  assign good_cnt_o = 16'h0000;
  assign bad_cnt_o  = 16'h0000;
`endif

endmodule
